mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequences the single shared memory port of the 5-stage MIPS pipeline between the IF-stage instruction fetch and the MEM-stage load/store. It grants one requester at a time and drives a variable-latency RAM through a req/ack handshake. It returns read data and a one-cycle completion pulse, and generates the per-stage stall signals that freeze the pipeline while a request is pending. MEM has priority, because it holds the older instruction; a starvation limit guarantees forward progress for IF.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive MEM grants allowed while IF waits (must be ≥1)

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset_0  in  1  reset, asynchronous and active-low
- if_req  in  1  fetch request, level; held until if_done
- if_addr  in  ADDR_W  fetch address, stable while if_req=1
- if_rdata  out  DATA_W  fetched word; valid while if_done=1
- if_done  out  1  one-cycle completion pulse for IF
- mem_req  in  1  load/store request, level; held until mem_done
- mem_we  in  1  1=store, 0=load
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data; valid while mem_done=1
- mem_done  out  1  one-cycle completion pulse for MEM
- ram_req  out  1  RAM request, registered
- ram_we  out  1  RAM write enable, registered
- ram_addr  out  ADDR_W  RAM address, registered
- ram_wdata  out  DATA_W  RAM write data, registered
- ram_rdata  in  DATA_W  RAM read data; valid in the ram_ack cycle
- ram_ack  in  1  one-cycle RAM completion
- stall_if  out  1  combinational: if_req & ~if_done
- stall_mem  out  1  combinational: mem_req & ~mem_done

## Operation
- FSM states: IDLE, BUSY, RESP. The owner register (IF/MEM) records which requester holds the grant.
- IDLE: the grant decision is made from if_req/mem_req.
  - If only one request is present, that requester gets the grant.
  - If both are present, MEM gets the grant unless starve_cnt==STARVE_MAX; in that case IF gets it.
  - On a grant: latch the owner's address/data/we into the ram_* registers, set ram_req=1, go to BUSY.
  - With no request, stay in IDLE.
- BUSY: hold ram_req and all ram_* outputs stable.
  - On ram_ack: capture ram_rdata into the owner's rdata register, drop ram_req, go to RESP.
- RESP: assert the owner's done for exactly this cycle, then go to IDLE.
  - Requests are not sampled in RESP. A req still high in the following IDLE cycle is a new request.
- starve_cnt behaviour:
  - Increments on each MEM grant made while if_req=1, saturating at STARVE_MAX.
  - Clears on every IF grant.
  - Clears on a MEM grant made while if_req=0.
- Stores: mem_rdata is don't-care, but it is still updated from ram_rdata. mem_done pulses as for a load.
- ram_ack outside BUSY is ignored; no state change occurs.
- Address/data changes on a requester's inputs after its grant have no effect until the next grant.

## Timing
- Reset values: state=IDLE, ram_req=0, ram_we=0, ram_addr=0, ram_wdata=0, if_done=0, mem_done=0, if_rdata=0, mem_rdata=0, starve_cnt=0.
- Reset mid-transaction aborts to IDLE. A late ram_ack after reset is ignored, and no done is issued.
- Latency from a request seen in IDLE at edge N:
  - ram_req=1 from N+1.
  - With ram_ack at cycle N+k (k≥1), done is high in cycle N+k+1.
  - Minimum is 3 cycles from request to done; back-to-back transactions start every 3+ cycles.
- Simultaneous if_req and mem_req in IDLE are resolved by the priority/starvation rule only. The loser's stall stays high.
- stall_* deasserts in the done cycle, so the stage advances on the edge that ends RESP.

## Structure
- Shared package (pipeline_pkg): arbiter state enum (IDLE/BUSY/RESP) and owner encoding (OWN_IF=0, OWN_MEM=1).
- Single module, no sub-modules. starve_cnt width is $clog2(STARVE_MAX+1).

## Test plan
- Single IF fetch:
  - Stimulus: if_req=1, if_addr=0x0000_0040; RAM acks 2 cycles after ram_req with rdata=0x2008_0005.
  - Response: ram_addr=0x40 and ram_we=0; if_done pulses once with if_rdata=0x2008_0005; stall_if is high until the done cycle.
- Store:
  - Stimulus: mem_req=1, mem_we=1, mem_addr=0x100, mem_wdata=0xDEAD_BEEF.
  - Response: ram_we=1, ram_addr=0x100, ram_wdata=0xDEAD_BEEF, all stable until ack; one mem_done pulse.
- Contention:
  - Stimulus: if_req and mem_req rise together.
  - Response: MEM is served first; IF is granted in the IDLE following the MEM RESP; stall_if stays 1 throughout the MEM transaction.
- Starvation:
  - Stimulus: if_req held; mem_req reasserted every IDLE; STARVE_MAX=4.
  - Response: exactly 4 MEM grants, then an IF grant, then starve_cnt=0.
- Reset during BUSY:
  - Stimulus: reset_0 pulled low before ram_ack; ack arrives after reset is released.
  - Response: all outputs return to reset values immediately; no done pulses; the stray ack is ignored.
- Zero-wait RAM:
  - Stimulus: ram_ack 1 cycle after ram_req, with continuous alternating requests.
  - Response: one done every 3 cycles, and the owner pattern obeys priority.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline memory-port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, BUSY, RESP)
//   owner_t     : which requester holds the memory port grant
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single memory port between the IF-stage fetch and the MEM-stage
// load/store. MEM has priority (older instruction), except that after
// STARVE_MAX consecutive MEM grants made while IF waits, IF wins the next
// contended grant.
// Ports:
//   clock, reset_0                 clock, async active-low reset
//   if_req/if_addr                 fetch request (level) and address
//   if_rdata/if_done               fetched word and one-cycle completion pulse
//   mem_req/mem_we/mem_addr/wdata  load/store request (level) and operands
//   mem_rdata/mem_done             load data and one-cycle completion pulse
//   ram_req/we/addr/wdata          registered RAM request bus
//   ram_rdata/ram_ack              RAM read data and one-cycle completion
//   stall_if/stall_mem             per-stage stall, high while a request is pending
module mem_port_arbiter
    import pipeline_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset_0,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int               CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_t        state_r;
    arb_state_t        state_nxt_s;
    owner_t            owner_r;
    owner_t            grant_own_s;
    logic              grant_s;
    logic              ack_s;
    logic [CNT_W-1:0]  starve_cnt_r;
    logic              ram_req_r;
    logic              ram_we_r;
    logic [ADDR_W-1:0] ram_addr_r;
    logic [DATA_W-1:0] ram_wdata_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] mem_rdata_r;
    logic              if_done_r;
    logic              mem_done_r;

    // Next-state and grant decision; requests are only looked at in IDLE
    always_comb begin
        state_nxt_s = state_r;
        grant_s     = 1'b0;
        grant_own_s = OWN_MEM;
        ack_s       = 1'b0;
        case (state_r)
            IDLE: begin
                // MEM wins unless IF is waiting and the starvation limit is hit
                if (mem_req && (!if_req || (starve_cnt_r != STARVE_LIM))) begin
                    grant_s     = 1'b1;
                    grant_own_s = OWN_MEM;
                    state_nxt_s = BUSY;
                end else if (if_req) begin
                    grant_s     = 1'b1;
                    grant_own_s = OWN_IF;
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (ram_ack) begin
                    ack_s       = 1'b1;
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            RESP: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Owner register and starvation counter, both updated only on a grant
    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            owner_r      <= OWN_IF;
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (grant_s) begin
            owner_r <= grant_own_s;
            if (grant_own_s == OWN_MEM && if_req) begin
                if (starve_cnt_r != STARVE_LIM) begin
                    starve_cnt_r <= starve_cnt_r + CNT_W'(1'b1);
                end else begin
                    starve_cnt_r <= starve_cnt_r;
                end
            end else begin
                // IF grant, or MEM grant with nobody waiting
                starve_cnt_r <= {CNT_W{1'b0}};
            end
        end else begin
            owner_r      <= owner_r;
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // RAM request bus: loaded on grant, frozen through BUSY, req dropped on ack
    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            ram_req_r   <= 1'b0;
            ram_we_r    <= 1'b0;
            ram_addr_r  <= {ADDR_W{1'b0}};
            ram_wdata_r <= {DATA_W{1'b0}};
        end else if (grant_s) begin
            ram_req_r <= 1'b1;
            if (grant_own_s == OWN_MEM) begin
                ram_we_r    <= mem_we;
                ram_addr_r  <= mem_addr;
                ram_wdata_r <= mem_wdata;
            end else begin
                ram_we_r    <= 1'b0;
                ram_addr_r  <= if_addr;
                ram_wdata_r <= {DATA_W{1'b0}};
            end
        end else if (ack_s) begin
            ram_req_r <= 1'b0;
        end else begin
            ram_req_r <= ram_req_r;
        end
    end

    // Read-data capture and done pulses; done is high exactly in RESP
    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            if_rdata_r  <= {DATA_W{1'b0}};
            mem_rdata_r <= {DATA_W{1'b0}};
            if_done_r   <= 1'b0;
            mem_done_r  <= 1'b0;
        end else begin
            if_done_r  <= ack_s && (owner_r == OWN_IF);
            mem_done_r <= ack_s && (owner_r == OWN_MEM);
            if (ack_s && (owner_r == OWN_IF)) begin
                if_rdata_r <= ram_rdata;
            end else begin
                if_rdata_r <= if_rdata_r;
            end
            // Stores also refresh mem_rdata; the value is simply unused
            if (ack_s && (owner_r == OWN_MEM)) begin
                mem_rdata_r <= ram_rdata;
            end else begin
                mem_rdata_r <= mem_rdata_r;
            end
        end
    end

    assign ram_req   = ram_req_r;
    assign ram_we    = ram_we_r;
    assign ram_addr  = ram_addr_r;
    assign ram_wdata = ram_wdata_r;
    assign if_rdata  = if_rdata_r;
    assign mem_rdata = mem_rdata_r;
    assign if_done   = if_done_r;
    assign mem_done  = mem_done_r;

    // Stalls drop in the done cycle so the stage advances on the edge ending RESP
    assign stall_if  = if_req & ~if_done_r;
    assign stall_mem = mem_req & ~mem_done_r;

endmodule
